// File: rtl/glb_core_strm_rd_responder.sv
// glb_core_strm_rd_responder: tile-side stream read responder.
// Queues local read hits, issues them to banks, returns data in order.
module glb_core_strm_rd_responder #(
   parameter int TILE_SEL_ADDR_WIDTH = 4,
   parameter int BANK_SEL_ADDR_WIDTH = 1,
   parameter int BANK_ADDR_WIDTH     = 17,
   parameter int BANK_DATA_WIDTH     = 64,
   parameter int RD_LATENCY          = 2,
   parameter int FIFO_DEPTH          = 4
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   clk_en,
   input  logic [TILE_SEL_ADDR_WIDTH-1:0]         glb_tile_id,
   input  logic                                   req_rd_en,
   input  logic [TILE_SEL_ADDR_WIDTH+BANK_SEL_ADDR_WIDTH+BANK_ADDR_WIDTH-1:0]
                                                  req_rd_addr,
   output logic [2**BANK_SEL_ADDR_WIDTH-1:0]      bank_rd_req,
   input  logic [2**BANK_SEL_ADDR_WIDTH-1:0]      bank_rd_gnt,
   output logic [2**BANK_SEL_ADDR_WIDTH-1:0]      bank_rd_en,
   output logic [BANK_ADDR_WIDTH-1:0]             bank_rd_addr,
   input  logic [(2**BANK_SEL_ADDR_WIDTH)*BANK_DATA_WIDTH-1:0]
                                                  bank_rd_data,
   output logic                                   rsp_rd_data_valid,
   output logic [BANK_DATA_WIDTH-1:0]             rsp_rd_data,
   output logic                                   err_overflow
);

   localparam int NUM_BANKS = 2**BANK_SEL_ADDR_WIDTH;
   localparam int ADDR_W    = TILE_SEL_ADDR_WIDTH + BANK_SEL_ADDR_WIDTH
                              + BANK_ADDR_WIDTH;
   localparam int ENT_W     = BANK_SEL_ADDR_WIDTH + BANK_ADDR_WIDTH;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;

   logic [TILE_SEL_ADDR_WIDTH-1:0] req_tile;
   logic [BANK_SEL_ADDR_WIDTH-1:0] req_bank;
   logic [BANK_ADDR_WIDTH-1:0]     req_baddr;
   logic                           hit;
   logic                           push;
   logic                           pop;
   logic                           full;
   logic                           empty;

   logic [ENT_W-1:0]               mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           err_q, err_d;

   logic [BANK_SEL_ADDR_WIDTH-1:0] head_bank;
   logic [BANK_ADDR_WIDTH-1:0]     head_addr;

   logic [RD_LATENCY-1:0]          vld_q, vld_d;
   logic [RD_LATENCY-1:0][BANK_SEL_ADDR_WIDTH-1:0] sel_q, sel_d;

   logic [BANK_DATA_WIDTH-1:0]     ret_data;
   logic                           rsp_vld_q, rsp_vld_d;
   logic [BANK_DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;

   assign req_tile  = req_rd_addr[ADDR_W-1 -: TILE_SEL_ADDR_WIDTH];
   assign req_bank  = req_rd_addr[BANK_ADDR_WIDTH +: BANK_SEL_ADDR_WIDTH];
   assign req_baddr = req_rd_addr[BANK_ADDR_WIDTH-1:0];
   assign hit       = clk_en & req_rd_en & (req_tile == glb_tile_id);

   assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign {head_bank, head_addr} = mem_q[rd_ptr_q];

   // Head of queue requests its bank; a grant issues and pops it.
   always_comb begin
      bank_rd_req  = '0;
      bank_rd_addr = '0;
      if (clk_en && !empty) begin
         bank_rd_req[head_bank] = 1'b1;
         bank_rd_addr           = head_addr;
      end
   end

   assign bank_rd_en = bank_rd_req & bank_rd_gnt;
   assign pop        = |bank_rd_en;
   // A full queue still takes a push when the head leaves this cycle.
   assign push       = hit & (~full | pop);

   // Queue pointer, occupancy and sticky overflow next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (hit && full && !pop) err_d = 1'b1;
   end

   // In-flight tracker shifts {valid, bank} once per enabled cycle.
   always_comb begin
      vld_d    = '0;
      sel_d    = '0;
      vld_d[0] = pop;
      sel_d[0] = head_bank;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         sel_d[i] = sel_q[i-1];
      end
   end

   // Select the returning bank's data slice at the last tracker stage.
   always_comb begin
      ret_data = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (sel_q[RD_LATENCY-1] == BANK_SEL_ADDR_WIDTH'(b))
            ret_data = bank_rd_data[b*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
      end
   end

   // Response register; data holds when nothing returns.
   always_comb begin
      rsp_vld_d  = vld_q[RD_LATENCY-1];
      rsp_data_d = rsp_data_q;
      if (vld_q[RD_LATENCY-1]) rsp_data_d = ret_data;
   end

   // Queue storage is written only on an accepted push.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {req_bank, req_baddr};
   end

   // Control state; everything freezes while clk_en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         vld_q      <= '0;
         sel_q      <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
      end else if (clk_en) begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         vld_q      <= vld_d;
         sel_q      <= sel_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign rsp_rd_data_valid = rsp_vld_q;
   assign rsp_rd_data       = rsp_data_q;
   assign err_overflow      = err_q;

endmodule

// File: tb/tb_glb_core_strm_rd_responder.sv
// tb_glb_core_strm_rd_responder: directed bench for the read responder.
// Includes a two-cycle bank model gated by clk_en.
module tb_glb_core_strm_rd_responder;

   logic         clk;
   logic         reset;
   logic         clk_en;
   logic [3:0]   glb_tile_id;
   logic         req_rd_en;
   logic [21:0]  req_rd_addr;
   logic [1:0]   bank_rd_req;
   logic [1:0]   bank_rd_gnt;
   logic [1:0]   bank_rd_en;
   logic [16:0]  bank_rd_addr;
   logic [127:0] bank_rd_data;
   logic         rsp_rd_data_valid;
   logic [63:0]  rsp_rd_data;
   logic         err_overflow;

   int checks = 0;
   int errors = 0;

   glb_core_strm_rd_responder dut (
      .clk               (clk),
      .reset             (reset),
      .clk_en            (clk_en),
      .glb_tile_id       (glb_tile_id),
      .req_rd_en         (req_rd_en),
      .req_rd_addr       (req_rd_addr),
      .bank_rd_req       (bank_rd_req),
      .bank_rd_gnt       (bank_rd_gnt),
      .bank_rd_en        (bank_rd_en),
      .bank_rd_addr      (bank_rd_addr),
      .bank_rd_data      (bank_rd_data),
      .rsp_rd_data_valid (rsp_rd_data_valid),
      .rsp_rd_data       (rsp_rd_data),
      .err_overflow      (err_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank contents: one fixed word, otherwise tagged by bank and address.
   function automatic logic [63:0] bdata(input int b, input logic [16:0] a);
      if (b == 1 && a == 17'h100) return 64'hDEADBEEF;
      return {16'hB000 + 16'(b), 31'd0, a};
   endfunction

   logic [1:0]  p_en0 = '0;
   logic [1:0]  p_en1 = '0;
   logic [16:0] p_a0  = '0;
   logic [16:0] p_a1  = '0;

   // Bank pipeline: strobe in cycle N, data visible in cycle N+2.
   always @(posedge clk) begin
      if (clk_en) begin
         p_en0 <= bank_rd_en;
         p_a0  <= bank_rd_addr;
         p_en1 <= p_en0;
         p_a1  <= p_a0;
      end
   end

   always_comb begin
      bank_rd_data = {2{64'h5555_5555_5555_5555}};
      if (p_en1[0]) bank_rd_data[63:0]   = bdata(0, p_a1);
      if (p_en1[1]) bank_rd_data[127:64] = bdata(1, p_a1);
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [21:0] mk(input logic [3:0] t, input logic b,
                                      input logic [16:0] a);
      return {t, b, a};
   endfunction

   task automatic reset_dut();
      reset       = 1'b1;
      clk_en      = 1'b1;
      req_rd_en   = 1'b0;
      bank_rd_gnt = 2'b00;
      repeat (3) tick();
      #2;
      chk("rst req",  64'(bank_rd_req), 64'h0);
      chk("rst en",   64'(bank_rd_en), 64'h0);
      chk("rst addr", 64'(bank_rd_addr), 64'h0);
      chk("rst vld",  64'(rsp_rd_data_valid), 64'h0);
      chk("rst data", rsp_rd_data, 64'h0);
      chk("rst err",  64'(err_overflow), 64'h0);
      reset = 1'b0;
   endtask

   logic [16:0] t3_addr [4] = '{17'h10, 17'h20, 17'h30, 17'h40};
   logic        t3_bank [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [1:0]  t3_en   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [16:0] t4_addr [5] = '{17'h50, 17'h51, 17'h52, 17'h53, 17'h77};
   logic        t4_bank [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [1:0]  t4_en   [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

   initial begin
      reset        = 1'b1;
      clk_en       = 1'b1;
      glb_tile_id  = 4'd3;
      req_rd_en    = 1'b0;
      req_rd_addr  = '0;
      bank_rd_gnt  = 2'b00;
      reset_dut();

      // single hit
      for (int c = 0; c < 6; c++) begin
         tick();
         req_rd_en   = (c == 0);
         req_rd_addr = mk(4'd3, 1'b1, 17'h100);
         bank_rd_gnt = 2'b11;
         #2;
         if (c == 0) chk("t1 nobypass", 64'(bank_rd_req), 64'h0);
         if (c == 1) begin
            chk("t1 en", 64'(bank_rd_en), 64'h2);
            chk("t1 addr", 64'(bank_rd_addr), 64'h100);
         end
         if (c < 4) chk($sformatf("t1 vld c%0d", c),
                        64'(rsp_rd_data_valid), 64'h0);
         if (c == 4) begin
            chk("t1 vld", 64'(rsp_rd_data_valid), 64'h1);
            chk("t1 data", rsp_rd_data, 64'hDEADBEEF);
         end
         if (c == 5) begin
            chk("t1 vld off", 64'(rsp_rd_data_valid), 64'h0);
            chk("t1 hold", rsp_rd_data, 64'hDEADBEEF);
         end
      end

      // miss
      for (int c = 0; c < 5; c++) begin
         tick();
         req_rd_en   = (c == 0);
         req_rd_addr = mk(4'd5, 1'b1, 17'h100);
         #2;
         if (c > 0) begin
            chk($sformatf("t2 req c%0d", c), 64'(bank_rd_req), 64'h0);
            chk($sformatf("t2 vld c%0d", c), 64'(rsp_rd_data_valid), 64'h0);
         end
      end

      // back-to-back with grant stall
      reset_dut();
      for (int c = 0; c < 14; c++) begin
         tick();
         req_rd_en = (c < 4);
         if (c < 4) req_rd_addr = mk(4'd3, t3_bank[c], t3_addr[c]);
         bank_rd_gnt = (c >= 6) ? 2'b11 : 2'b00;
         #2;
         if (c == 4 || c == 5) begin
            chk($sformatf("t3 req c%0d", c), 64'(bank_rd_req), 64'h1);
            chk($sformatf("t3 stall c%0d", c), 64'(bank_rd_en), 64'h0);
         end
         if (c >= 6 && c <= 9) begin
            chk($sformatf("t3 en c%0d", c), 64'(bank_rd_en),
                64'(t3_en[c-6]));
            chk($sformatf("t3 addr c%0d", c), 64'(bank_rd_addr),
                64'(t3_addr[c-6]));
         end
         if (c >= 9 && c <= 12) begin
            chk($sformatf("t3 vld c%0d", c), 64'(rsp_rd_data_valid), 64'h1);
            chk($sformatf("t3 data c%0d", c), rsp_rd_data,
                bdata(int'(t3_bank[c-9]), t3_addr[c-9]));
         end
         if (c == 13) chk("t3 vld end", 64'(rsp_rd_data_valid), 64'h0);
         if (c == 10) chk("t3 empty", 64'(bank_rd_req), 64'h0);
      end

      // overflow, then push with pop while full
      reset_dut();
      for (int c = 0; c < 15; c++) begin
         tick();
         req_rd_en = (c < 5) || (c == 6);
         if (c < 5) req_rd_addr = mk(4'd3, 1'b0, 17'h50 + 17'(c));
         if (c == 6) req_rd_addr = mk(4'd3, 1'b1, 17'h77);
         bank_rd_gnt = (c >= 6) ? 2'b11 : 2'b00;
         #2;
         if (c == 4) chk("t4 err pre", 64'(err_overflow), 64'h0);
         if (c >= 5) chk($sformatf("t4 err c%0d", c),
                         64'(err_overflow), 64'h1);
         if (c >= 6 && c <= 10) begin
            chk($sformatf("t4 en c%0d", c), 64'(bank_rd_en),
                64'(t4_en[c-6]));
            chk($sformatf("t4 addr c%0d", c), 64'(bank_rd_addr),
                64'(t4_addr[c-6]));
         end
         if (c == 11) chk("t4 empty", 64'(bank_rd_req), 64'h0);
         if (c >= 9 && c <= 13)
            chk($sformatf("t4 data c%0d", c), rsp_rd_data,
                bdata(int'(t4_bank[c-9]), t4_addr[c-9]));
         if (c == 14) chk("t4 vld end", 64'(rsp_rd_data_valid), 64'h0);
      end

      // clk_en freeze with a read in flight
      reset_dut();
      for (int c = 0; c < 10; c++) begin
         tick();
         clk_en      = !(c >= 2 && c <= 4);
         bank_rd_gnt = 2'b11;
         req_rd_en   = (c <= 1) || (c == 3);
         if (c == 0) req_rd_addr = mk(4'd3, 1'b0, 17'h60);
         if (c == 1) req_rd_addr = mk(4'd3, 1'b1, 17'h61);
         if (c == 3) req_rd_addr = mk(4'd3, 1'b0, 17'h6F);
         #2;
         if (c == 1) begin
            chk("t5 en c1", 64'(bank_rd_en), 64'h1);
            chk("t5 addr c1", 64'(bank_rd_addr), 64'h60);
         end
         if (c >= 2 && c <= 4) begin
            chk($sformatf("t5 frz en c%0d", c), 64'(bank_rd_en), 64'h0);
            chk($sformatf("t5 frz req c%0d", c), 64'(bank_rd_req), 64'h0);
         end
         if (c == 5) begin
            chk("t5 en c5", 64'(bank_rd_en), 64'h2);
            chk("t5 addr c5", 64'(bank_rd_addr), 64'h61);
         end
         if (c == 6) chk("t5 ignored", 64'(bank_rd_req), 64'h0);
         if (c >= 4 && c <= 6)
            chk($sformatf("t5 vld c%0d", c), 64'(rsp_rd_data_valid), 64'h0);
         if (c == 7) begin
            chk("t5 vld c7", 64'(rsp_rd_data_valid), 64'h1);
            chk("t5 data c7", rsp_rd_data, bdata(0, 17'h60));
         end
         if (c == 8) begin
            chk("t5 vld c8", 64'(rsp_rd_data_valid), 64'h1);
            chk("t5 data c8", rsp_rd_data, bdata(1, 17'h61));
         end
         if (c == 9) chk("t5 vld c9", 64'(rsp_rd_data_valid), 64'h0);
      end

      // reset mid-flight
      for (int c = 0; c < 9; c++) begin
         tick();
         clk_en      = 1'b1;
         bank_rd_gnt = 2'b11;
         reset       = (c == 2);
         req_rd_en   = (c <= 1);
         if (c == 0) req_rd_addr = mk(4'd3, 1'b1, 17'h100);
         if (c == 1) req_rd_addr = mk(4'd3, 1'b0, 17'h22);
         #2;
         if (c == 1) chk("t6 en", 64'(bank_rd_en), 64'h2);
         if (c == 2) begin
            chk("t6 rst en", 64'(bank_rd_en), 64'h0);
            chk("t6 rst addr", 64'(bank_rd_addr), 64'h0);
            chk("t6 rst data", rsp_rd_data, 64'h0);
            chk("t6 rst err", 64'(err_overflow), 64'h0);
         end
         if (c >= 2) begin
            chk($sformatf("t6 req c%0d", c), 64'(bank_rd_req), 64'h0);
            chk($sformatf("t6 vld c%0d", c), 64'(rsp_rd_data_valid), 64'h0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
